// File: rtl/norm_pkg.sv
// Shared types and constants for the min-max contrast-stretch normalizer.
// The NORM_ROUND_EN build option is consumed by the top-level module.
package norm_pkg;

    localparam int unsigned NORM_WIDTH = 7;
    localparam int unsigned W          = NORM_WIDTH + 1;
    localparam int unsigned MAXVAL     = (1 << W) - 1;

    typedef logic [W-1:0]   pixel_t;
    typedef logic [2*W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } norm_state_t;

    // Clamp a pixel into [lo, hi]; the result is ignored when hi <= lo.
    function automatic pixel_t clamp_pix(input pixel_t a, input pixel_t lo, input pixel_t hi);
        if (a < lo) begin
            return lo;
        end
        if (a > hi) begin
            return hi;
        end
        return a;
    endfunction

endpackage

// File: rtl/normalization_if.sv
// Pixel-in / pixel-out handshake bundle for the normalizer.
interface normalization_if;
    import norm_pkg::*;

    pixel_t A;
    pixel_t lo;
    pixel_t hi;
    logic   in_valid;
    logic   in_ready;
    pixel_t out;
    logic   out_valid;

    modport master (output A, lo, hi, in_valid, input in_ready, out, out_valid);
    modport slave  (input A, lo, hi, in_valid, output in_ready, out, out_valid);

endinterface

// File: rtl/norm_divider.sv
// W-cycle restoring unsigned divider: 2W-bit dividend, W-bit divisor, W-bit quotient.
// The caller guarantees the quotient fits in W bits (high half of n below d).
module norm_divider
    import norm_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  prod_t  n,
    input  pixel_t d,
    output pixel_t q,
    output logic   done_c
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    pixel_t           rem;
    pixel_t           quo;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [W:0]       trial;
    logic [W:0]       diff;
    logic             ge;

    // quo holds the unconsumed dividend bits and collects quotient bits from the bottom
    always_comb begin
        trial = {rem, quo[W-1]};
        diff  = trial - {1'b0, d};
        ge    = (trial >= {1'b0, d});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= n[2*W-1:W];
            quo  <= n[W-1:0];
            cnt  <= CNT_W'(W);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= ge ? W'(diff) : W'(trial);
            quo  <= {quo[W-2:0], ge};
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign q      = quo;
    assign done_c = busy && (cnt == CNT_W'(1));

endmodule

// File: rtl/normalization.sv
// Min-max contrast-stretch normalizer: maps A from [lo, hi] onto [0, MAXVAL].
// Define NORM_ROUND_EN for round-half-up instead of floor division.
module normalization
    import norm_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    normalization_if.slave  bus
);

    localparam pixel_t MAXV = pixel_t'(MAXVAL);

    norm_state_t state, state_n;
    pixel_t      a_q, lo_q, hi_q;
    pixel_t      out_q, result_c;
    logic        out_valid_q, out_valid_n;
    logic        in_ready_q, in_ready_n;
    logic        xfer_c, start_c, div_done_c;
    pixel_t      a_c, d_c, q;
    prod_t       n_c;

    // Divider operands, consumed on the LOAD cycle
    always_comb begin
        a_c = clamp_pix(a_q, lo_q, hi_q);
        d_c = hi_q - lo_q;
`ifdef NORM_ROUND_EN
        n_c = prod_t'(a_c - lo_q) * prod_t'(MAXVAL) + prod_t'(d_c >> 1);
`else
        n_c = prod_t'(a_c - lo_q) * prod_t'(MAXVAL);
`endif
    end

    norm_divider u_div (
        .clk    (clk),
        .reset  (reset),
        .start  (start_c),
        .n      (n_c),
        .d      (d_c),
        .q      (q),
        .done_c (div_done_c)
    );

    // Degenerate window first, then clamps, then the quotient
    always_comb begin
        if (hi_q <= lo_q) begin
            result_c = (a_q > lo_q) ? MAXV : '0;
        end else if (a_q <= lo_q) begin
            result_c = '0;
        end else if (a_q >= hi_q) begin
            result_c = MAXV;
        end else begin
            result_c = q;
        end
    end

    always_comb begin
        state_n     = state;
        out_valid_n = 1'b0;
        xfer_c      = 1'b0;
        start_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    xfer_c  = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                start_c = 1'b1;
                state_n = DIV;
            end
            DIV: begin
                if (div_done_c) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
        in_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            a_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
        end else begin
            state       <= state_n;
            out_valid_q <= out_valid_n;
            in_ready_q  <= in_ready_n;
            if (out_valid_n) begin
                out_q <= result_c;
            end
            if (xfer_c) begin
                a_q  <= bus.A;
                lo_q <= bus.lo;
                hi_q <= bus.hi;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_normalization.sv
// Self-checking bench for normalization: vector table, scoreboard queue, reset/abort and back-to-back sequences.
module tb_normalization;
    import norm_pkg::*;

    typedef struct {
        pixel_t a;
        pixel_t lo;
        pixel_t hi;
        pixel_t exp;
        string  name;
    } vec_t;

    typedef struct {
        pixel_t exp;
        int     xfer;
        string  name;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    normalization_if nif ();

    normalization dut (
        .clk   (clk),
        .reset (reset),
        .bus   (nif.slave)
    );

    sb_t  sbq[$];
    vec_t vecs[12];
    int   checks = 0;
    int   passes = 0;
    int   valid_cnt = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance to the next falling edge and check any result the DUT presents there
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (!reset && nif.out_valid) begin
            valid_cnt++;
            chk("out_valid_single_cycle", int'(prev_valid), 0);
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk(e.name, int'(nif.out), int'(e.exp));
                chk({e.name, "_latency"}, cyc - e.xfer, W + 2);
            end
        end
        prev_valid = nif.out_valid;
    endtask

    task automatic send(input pixel_t a, input pixel_t lo, input pixel_t hi,
                        input pixel_t exp, input string name);
        sb_t e;
        bit  accepted = 1'b0;
        nif.A        = a;
        nif.lo       = lo;
        nif.hi       = hi;
        nif.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (nif.in_ready) begin
                e.exp  = exp;
                e.xfer = cyc + 1;
                e.name = name;
                sbq.push_back(e);
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        if (!accepted) chk({name, "_accept"}, int'(accepted), 1);
        nif.in_valid = 1'b0;
        nif.A        = ~a;
        nif.lo       = ~lo;
        nif.hi       = ~hi;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sbq.size() > 0; i++) tick();
        chk("drain_pending", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int prev_x;
        int n_acc;
        pixel_t ra;
        sb_t e;

        vecs[0]  = '{8'd234, 8'd0,   8'd255, 8'd234, "full_234"};
        vecs[1]  = '{8'd192, 8'd0,   8'd255, 8'd192, "full_192"};
        vecs[2]  = '{8'd192, 8'd64,  8'd192, 8'd255, "a_eq_hi"};
        vecs[3]  = '{8'd234, 8'd64,  8'd192, 8'd255, "clamp_hi"};
        vecs[4]  = '{8'd30,  8'd64,  8'd192, 8'd0,   "clamp_lo"};
        vecs[5]  = '{8'd64,  8'd64,  8'd192, 8'd0,   "a_eq_lo"};
`ifdef NORM_ROUND_EN
        vecs[6]  = '{8'd100, 8'd64,  8'd192, 8'd72,  "mid_100"};
        vecs[7]  = '{8'd128, 8'd64,  8'd192, 8'd128, "mid_128"};
`else
        vecs[6]  = '{8'd100, 8'd64,  8'd192, 8'd71,  "mid_100"};
        vecs[7]  = '{8'd128, 8'd64,  8'd192, 8'd127, "mid_128"};
`endif
        vecs[8]  = '{8'd160, 8'd64,  8'd192, 8'd191, "mid_160"};
        vecs[9]  = '{8'd100, 8'd100, 8'd100, 8'd0,   "degen_eq_at"};
        vecs[10] = '{8'd101, 8'd100, 8'd100, 8'd255, "degen_eq_above"};
        vecs[11] = '{8'd10,  8'd200, 8'd50,  8'd0,   "degen_inverted"};

        nif.A        = '0;
        nif.lo       = '0;
        nif.hi       = '0;
        nif.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_out", int'(nif.out), 0);
        chk("reset_out_valid", int'(nif.out_valid), 0);
        chk("reset_in_ready", int'(nif.in_ready), 1);

        foreach (vecs[i]) send(vecs[i].a, vecs[i].lo, vecs[i].hi, vecs[i].exp, vecs[i].name);
        drain();

        // Abort a transaction in the middle of the divide phase
        send(8'd50, 8'd0, 8'd255, 8'd50, "aborted");
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();
        chk("abort_in_ready", int'(nif.in_ready), 1);
        chk("abort_out_valid", int'(nif.out_valid), 0);
        v0 = valid_cnt;
        repeat (15) tick();
        chk("abort_no_pulse", valid_cnt, v0);
        send(8'd77, 8'd0, 8'd255, 8'd77, "post_abort");
        drain();

        // in_valid held high with a new pixel every cycle: only IDLE-cycle pixels are taken
        prev_x = -1;
        n_acc  = 0;
        for (int i = 0; i < 60; i++) begin
            ra           = pixel_t'($urandom_range(0, 255));
            nif.A        = ra;
            nif.lo       = 8'd0;
            nif.hi       = 8'd255;
            nif.in_valid = 1'b1;
            if (nif.in_ready) begin
                e.exp  = ra;
                e.xfer = cyc + 1;
                e.name = "b2b";
                sbq.push_back(e);
                if (prev_x >= 0) chk("b2b_spacing", cyc + 1 - prev_x, W + 3);
                prev_x = cyc + 1;
                n_acc++;
            end
            tick();
        end
        nif.in_valid = 1'b0;
        chk("b2b_accept_count", n_acc, 6);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
